// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states, CSR
// addresses/masks matching the CSR file, cause codes and mstatus/mie bit positions.
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_MEPC   = 3'd1,
        ST_W_MCAUSE = 3'd2,
        ST_W_MSTAT  = 3'd3,
        ST_JUMP     = 3'd4
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // Writable-bit masks; must stay identical to the CSR file's masks.
    localparam logic [31:0] CSR_MSTATUS_MASK = 32'h0000_1888;
    localparam logic [31:0] CSR_MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] CSR_MTVEC_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] CSR_MEPC_MASK    = 32'hFFFF_FFFC;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'h0000_0002;
    localparam logic [31:0] CAUSE_EBREAK    = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL     = 32'h0000_000B;
    localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP  = 11;

    localparam int unsigned MIE_MTIE = 7;
    localparam int unsigned MIE_MEIE = 11;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
        logic [31:0] r;
        r                  = old;
        r[MSTATUS_MPIE]    = old[MSTATUS_MIE];
        r[MSTATUS_MIE]     = 1'b0;
        r[MSTATUS_MPP +: 2] = 2'b11;
        return r;
    endfunction

    // M-mode only: MPP is left at its current value on return.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
        logic [31:0] r;
        r               = old;
        r[MSTATUS_MIE]  = old[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// Combinational priority encoder selecting the trap/return taken by the EX instruction.
// Zero latency; purely a function of the current inputs and shadow enable bits.
module trap_cause_enc
    import trap_ctrl_pkg::*;
#(
    parameter bit IRQ_EN = 1'b1
) (
    input  logic        inst_valid_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic        mstatus_mie_i,
    input  logic        mie_mtie_i,
    input  logic        mie_meie_i,
    output logic        accept_o,
    output logic        is_mret_o,
    output logic [31:0] cause_o
);

    always_comb begin
        accept_o  = 1'b0;
        is_mret_o = 1'b0;
        cause_o   = 32'd0;
        if (inst_valid_i) begin
            if (IRQ_EN && irq_ext_i && mie_meie_i && mstatus_mie_i) begin
                accept_o = 1'b1;
                cause_o  = CAUSE_IRQ_EXT;
            end else if (IRQ_EN && irq_timer_i && mie_mtie_i && mstatus_mie_i) begin
                accept_o = 1'b1;
                cause_o  = CAUSE_IRQ_TIMER;
            end else if (illegal_i) begin
                accept_o = 1'b1;
                cause_o  = CAUSE_ILLEGAL;
            end else if (ecall_i) begin
                accept_o = 1'b1;
                cause_o  = CAUSE_ECALL;
            end else if (ebreak_i) begin
                accept_o = 1'b1;
                cause_o  = CAUSE_EBREAK;
            end else if (mret_i) begin
                accept_o  = 1'b1;
                is_mret_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer owning the CSR write port; traps take 4 cycles after
// accept (mepc, mcause, mstatus, jump), mret takes 2 (mstatus, jump).
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter bit IRQ_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic        ex_csr_we_i,
    input  logic [31:0] ex_csr_waddr_i,
    input  logic [31:0] ex_csr_wdata_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic        mret_q, mret_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;

    logic        accept;
    logic        is_mret;
    logic [31:0] cause;
    logic [31:0] mstat_nxt;

    trap_cause_enc #(
        .IRQ_EN (IRQ_EN)
    ) u_enc (
        .inst_valid_i  (inst_valid_i),
        .ecall_i       (ecall_i),
        .ebreak_i      (ebreak_i),
        .illegal_i     (illegal_i),
        .mret_i        (mret_i),
        .irq_timer_i   (irq_timer_i),
        .irq_ext_i     (irq_ext_i),
        .mstatus_mie_i (mstatus_q[MSTATUS_MIE]),
        .mie_mtie_i    (mie_q[MIE_MTIE]),
        .mie_meie_i    (mie_q[MIE_MEIE]),
        .accept_o      (accept),
        .is_mret_o     (is_mret),
        .cause_o       (cause)
    );

    assign mstat_nxt = mret_q ? mret_mstatus(mstatus_q) : trap_mstatus(mstatus_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        mret_d      = mret_q;
        mstatus_d   = mstatus_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        csr_we_o    = 1'b0;
        csr_waddr_o = 32'd0;
        csr_wdata_o = 32'd0;
        stall_o     = 1'b0;
        flush_o     = 1'b0;
        jump_o      = 1'b0;
        jump_addr_o = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // The trapping instruction's own CSR write is dropped here.
                    stall_o = 1'b1;
                    flush_o = 1'b1;
                    pc_d    = inst_pc_i;
                    cause_d = cause;
                    mret_d  = is_mret;
                    state_d = is_mret ? ST_W_MSTAT : ST_W_MEPC;
                end else begin
                    csr_we_o    = ex_csr_we_i;
                    csr_waddr_o = ex_csr_waddr_i;
                    csr_wdata_o = ex_csr_wdata_i;
                    if (ex_csr_we_i) begin
                        case (ex_csr_waddr_i[11:0])
                            CSR_MSTATUS: mstatus_d = ex_csr_wdata_i & CSR_MSTATUS_MASK;
                            CSR_MIE:     mie_d     = ex_csr_wdata_i & CSR_MIE_MASK;
                            CSR_MTVEC:   mtvec_d   = ex_csr_wdata_i & CSR_MTVEC_MASK;
                            CSR_MEPC:    mepc_d    = ex_csr_wdata_i & CSR_MEPC_MASK;
                            default: ;
                        endcase
                    end
                end
            end
            ST_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'd0, CSR_MEPC};
                csr_wdata_o = pc_q & ~32'h3;
                stall_o     = 1'b1;
                flush_o     = 1'b1;
                mepc_d      = pc_q & CSR_MEPC_MASK;
                state_d     = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'd0, CSR_MCAUSE};
                csr_wdata_o = cause_q;
                stall_o     = 1'b1;
                flush_o     = 1'b1;
                state_d     = ST_W_MSTAT;
            end
            ST_W_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'd0, CSR_MSTATUS};
                csr_wdata_o = mstat_nxt;
                stall_o     = 1'b1;
                flush_o     = 1'b1;
                mstatus_d   = mstat_nxt & CSR_MSTATUS_MASK;
                state_d     = ST_JUMP;
            end
            ST_JUMP: begin
                // Direct vectoring only: mtvec mode bits never reach the target.
                jump_o      = 1'b1;
                jump_addr_o = mret_q ? mepc_q : (mtvec_q & ~32'h3);
                flush_o     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset forces the port quiet immediately, even mid-sequence.
        if (rst) begin
            csr_we_o    = 1'b0;
            csr_waddr_o = 32'd0;
            csr_wdata_o = 32'd0;
            stall_o     = 1'b0;
            flush_o     = 1'b0;
            jump_o      = 1'b0;
            jump_addr_o = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= 32'd0;
            cause_q   <= 32'd0;
            mret_q    <= 1'b0;
            mstatus_q <= 32'd0;
            mie_q     <= 32'd0;
            mtvec_q   <= 32'd0;
            mepc_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cause_q   <= cause_d;
            mret_q    <= mret_d;
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
        end
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer sitting directly upstream of the CSR register file, owning its single write port. It arbitrates between the EX-stage CSR write and its own trap/return sequences (ecall, ebreak, illegal, mret, timer/external interrupt). It keeps shadow copies of mstatus/mie/mtvec/mepc, so it never waits on the registered CSR read path, and it drives stall/flush plus a redirect PC to the pipeline.

Parameters:
IRQ_EN, 1, 0 = interrupt inputs ignored, only synchronous traps and mret taken.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
inst_valid_i  in  1  EX holds a valid instruction this cycle
inst_pc_i  in  32  PC of that instruction
ecall_i / ebreak_i / illegal_i / mret_i  in  1 each  decoded EX-stage events, qualified by inst_valid_i
irq_timer_i / irq_ext_i  in  1 each  level interrupt requests
ex_csr_we_i  in  1  EX-stage CSR write request
ex_csr_waddr_i  in  32  EX CSR address, bits [11:0] significant
ex_csr_wdata_i  in  32  EX CSR write data
csr_we_o  out  1  write enable to CSR file
csr_waddr_o  out  32  write address to CSR file
csr_wdata_o  out  32  write data to CSR file
stall_o  out  1  freeze IF/ID/EX
flush_o  out  1  kill instructions in IF/ID/EX
jump_o  out  1  one-cycle redirect strobe
jump_addr_o  out  32  redirect target

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Shadows: mstatus, mie, mtvec, mepc all 0, matching CSR file reset values. Reset mid-sequence aborts immediately with no further writes.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, JUMP.
- IDLE pass-through (no trap accepted): csr_*_o = ex_csr_*_i combinationally.
  - An EX write to MSTATUS/MIE/MTVEC/MEPC also updates the matching shadow at the clock edge, using the same CSR_*_MASK as the CSR file.
- Trap accept (IDLE, inst_valid_i=1), priority highest first:
  - irq_ext_i & mie[11] & mstatus[3] & IRQ_EN, cause 0x8000000B
  - irq_timer_i & mie[7] & mstatus[3] & IRQ_EN, cause 0x80000007
  - illegal_i, cause 2
  - ecall_i, cause 11
  - ebreak_i, cause 3
  - mret_i (return, not a trap)
- On accept cycle T:
  - EX CSR write is suppressed (csr_we_o=0); the trapping instruction has no architectural effect.
  - stall_o=1 and flush_o=1 combinationally.
  - Latch inst_pc_i and cause.
- Trap sequence, one CSR write per cycle:
  - T+1 W_MEPC: write MEPC = latched PC & ~3.
  - T+2 W_MCAUSE: write MCAUSE = cause.
  - T+3 W_MSTAT: write MSTATUS with MPIE(bit7) = old MIE(bit3), MIE = 0, MPP[12:11] = 2'b11. Shadow updated identically.
  - T+4 JUMP: jump_o=1, jump_addr_o = {shadow mtvec[31:2], 2'b00} (direct mode only), flush_o=1, stall_o=0. Next state IDLE.
  - stall_o=1 T..T+3; flush_o=1 T..T+4.
- mret: T → W_MSTAT writes MIE = MPIE, MPIE = 1, then JUMP with jump_addr_o = shadow mepc. Total latency 2 cycles after T.
- While not IDLE:
  - ex_csr_* and all event/irq inputs are ignored (pipeline stalled).
  - Interrupts dropping mid-sequence do not abort the sequence.
- Back-to-back: the cycle after JUMP is IDLE and may accept a new trap; a pending interrupt is retaken only if MIE is set.
- jump_addr_o = 0 whenever jump_o = 0.

Decomposition:
- bitty_defs.v additions:
  - state encodings (3-bit)
  - cause codes CAUSE_ECALL/EBREAK/ILLEGAL/IRQ_EXT/IRQ_TIMER
  - mstatus bit positions MSTATUS_MIE/MPIE/MPP
  - mie bit positions MIE_MTIE/MEIE
- Reuse existing CSR address and mask defines.
- One natural sub-module: trap_cause_enc (combinational priority encoder → accept, is_mret, 32-bit cause). FSM and shadows stay in trap_ctrl.

Test Plan:
- ecall at pc 0x00000104, mtvec=0x00000200:
  - T+1 MEPC=0x104, T+2 MCAUSE=11, T+3 MSTATUS MIE→0.
  - T+4 jump_o=1, jump_addr_o=0x200.
- EX writes MSTATUS=0x8, MIE=0x800, then irq_ext_i=1 with irq_timer_i=1 and ecall_i=1 on the same instruction:
  - MCAUSE=0x8000000B, MSTATUS=0x1880.
- Trap then mret:
  - MSTATUS restores MIE=1, MPIE=1.
  - jump_addr_o equals previous MEPC, 2 cycles after accept.
- irq_timer_i=1 with mstatus MIE=0:
  - no accept, csr_we_o follows ex_csr_we_i, stall_o stays 0.
- rst asserted during W_MCAUSE:
  - outputs 0 immediately, no further CSR writes.
  - after release, IDLE; shadows 0.
- EX CSR write coincident with illegal_i:
  - csr_we_o=0 that cycle; the write never reaches the CSR file.
